command_decoder: RTL and testbench

Downstream consumer of the 48-bit UART receive stage in the Sigma Delta DAQ control path. Accepts CRC-validated 48-bit command messages over a valid/ready handshake. Executes register write/read/ping operations against an internal configuration register bank. Emits one 48-bit response per command to the transmit packetizer over a second valid/ready handshake.

---
 rtl/command_decoder_if.sv | 44 ++++
 rtl/command_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_command_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/command_decoder_if.sv
// ----------------------------------------------------------------------------
// command_decoder_if
//   Bundles the two valid/ready channels around the command decoder:
//   the command channel from the UART receive stage and the response
//   channel to the transmit packetizer.
//
//   Signals:
//     i_msg_data  [47:0]  command {opcode, address, data}
//     i_msg_valid         command valid
//     o_msg_ready         decoder can accept a command
//     o_rsp_data  [47:0]  response {status, address, data}
//     o_rsp_valid         response valid
//     i_rsp_ready         transmit stage accepts the response
//
//   Modports:
//     master - the surrounding system (drives commands, consumes responses)
//     slave  - the command decoder
// ----------------------------------------------------------------------------
interface command_decoder_if;
    logic [47:0] i_msg_data;
    logic        i_msg_valid;
    logic        o_msg_ready;
    logic [47:0] o_rsp_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;

    modport master (
        output i_msg_data,
        output i_msg_valid,
        input  o_msg_ready,
        input  o_rsp_data,
        input  o_rsp_valid,
        output i_rsp_ready
    );

    modport slave (
        input  i_msg_data,
        input  i_msg_valid,
        output o_msg_ready,
        output o_rsp_data,
        output o_rsp_valid,
        input  i_rsp_ready
    );
endinterface

// File: rtl/command_decoder.sv
// ----------------------------------------------------------------------------
// command_decoder
//   Executes CRC-validated 48-bit commands (WRITE / READ / PING) against an
//   internal bank of 32-bit configuration registers and returns exactly one
//   48-bit response per command. One command is in flight at a time:
//   IDLE -> DECODE -> EXECUTE -> RESPOND -> IDLE.
//
//   Ports:
//     clk       clock, rising edge
//     reset     synchronous, active-high
//     bus       command_decoder_if.slave (command in, response out)
//     o_cfg     flat register bank, register k at [k*32 +: 32]
//     i_status  read-only DAQ status word, readable at address 0xFF
//
//   Optional feature macro: CMD_DECODER_STATS_EN
//     Adds saturating 16-bit ok/error response counters at address 0xFE
//     (READ returns {err_count, ok_count}, WRITE clears both). Without the
//     macro, 0xFE is an ordinary bad address.
// ----------------------------------------------------------------------------
module command_decoder #(
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    command_decoder_if.slave         bus,
    output logic [NUM_REGS*32-1:0]   o_cfg,
    input  logic [31:0]              i_status
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [7:0] OP_WRITE     = 8'h01;
    localparam logic [7:0] OP_READ      = 8'h02;
    localparam logic [7:0] OP_PING      = 8'h03;
    localparam logic [7:0] ST_ILLEGAL   = 8'hE0;
    localparam logic [7:0] ST_BADADDR   = 8'hE1;
    localparam logic [7:0] ADDR_STATUS  = 8'hFF;
`ifdef CMD_DECODER_STATS_EN
    localparam logic [7:0] ADDR_STATS   = 8'hFE;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_RESPOND
    } state_t;

    typedef enum logic [2:0] {
        K_WRITE,
        K_READ,
        K_STATUS,
        K_PING,
        K_ILLEGAL,
        K_BADADDR,
        K_STATS_RD,
        K_STATS_CLR
    } kind_t;

    state_t      state;
    kind_t       kind_q;
    kind_t       kind_d;

    logic [7:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;

    logic        msg_ready;
    logic        rsp_valid;
    logic [47:0] rsp_data;

    logic [31:0] regs [NUM_REGS];
    logic [AW-1:0] reg_idx;
    logic          addr_ok;

    assign bus.o_msg_ready = msg_ready;
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_data  = rsp_data;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
        assign o_cfg[k*32 +: 32] = regs[k];
    end

    // Only meaningful when addr_ok; out-of-map addresses never index regs.
    assign reg_idx = cmd_addr[AW-1:0];
    assign addr_ok = ({1'b0, cmd_addr} < 9'(NUM_REGS));

`ifdef CMD_DECODER_STATS_EN
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic        rsp_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rsp_err = (rsp_data[47:40] == ST_ILLEGAL) || (rsp_data[47:40] == ST_BADADDR);
`endif

    // Illegal opcode is checked first so it wins over a bad address.
    always_comb begin
        kind_d = K_ILLEGAL;
        case (cmd_op)
            OP_WRITE: begin
                if (addr_ok) kind_d = K_WRITE;
`ifdef CMD_DECODER_STATS_EN
                else if (cmd_addr == ADDR_STATS) kind_d = K_STATS_CLR;
`endif
                else kind_d = K_BADADDR;
            end
            OP_READ: begin
                if (addr_ok) kind_d = K_READ;
                else if (cmd_addr == ADDR_STATUS) kind_d = K_STATUS;
`ifdef CMD_DECODER_STATS_EN
                else if (cmd_addr == ADDR_STATS) kind_d = K_STATS_RD;
`endif
                else kind_d = K_BADADDR;
            end
            OP_PING: kind_d = K_PING;
            default: kind_d = K_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            msg_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            kind_q    <= K_ILLEGAL;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            case (state)
                // ---- IDLE: accept and capture one command ----
                S_IDLE: begin
                    if (bus.i_msg_valid && msg_ready) begin
                        cmd_op    <= bus.i_msg_data[47:40];
                        cmd_addr  <= bus.i_msg_data[39:32];
                        cmd_data  <= bus.i_msg_data[31:0];
                        msg_ready <= 1'b0;
                        state     <= S_DECODE;
                    end else begin
                        msg_ready <= 1'b1;
                    end
                end
                // ---- DECODE: latch classification ----
                S_DECODE: begin
                    kind_q <= kind_d;
                    state  <= S_EXECUTE;
                end
                // ---- EXECUTE: side effects and response load ----
                S_EXECUTE: begin
                    case (kind_q)
                        K_WRITE: begin
                            regs[reg_idx] <= cmd_data;
                            rsp_data      <= {OP_WRITE, cmd_addr, cmd_data};
                        end
                        K_READ:    rsp_data <= {OP_READ, cmd_addr, regs[reg_idx]};
                        K_STATUS:  rsp_data <= {OP_READ, cmd_addr, i_status};
                        K_PING:    rsp_data <= {OP_PING, cmd_addr, cmd_data};
                        K_ILLEGAL: rsp_data <= {ST_ILLEGAL, cmd_addr, 32'h0};
`ifdef CMD_DECODER_STATS_EN
                        K_STATS_RD:  rsp_data <= {OP_READ, cmd_addr, err_count, ok_count};
                        K_STATS_CLR: rsp_data <= {OP_WRITE, cmd_addr, 32'h0};
`endif
                        default:   rsp_data <= {ST_BADADDR, cmd_addr, 32'h0};
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= S_RESPOND;
                end
                // ---- RESPOND: hold until the transmit stage takes it ----
                S_RESPOND: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        msg_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CMD_DECODER_STATS_EN
    // Clear happens in EXECUTE and counting on the RESPOND handshake, so the
    // clearing command's own ok response is counted after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_count  <= '0;
            err_count <= '0;
        end else if (state == S_EXECUTE && kind_q == K_STATS_CLR) begin
            ok_count  <= '0;
            err_count <= '0;
        end else if (state == S_RESPOND && bus.i_rsp_ready) begin
            if (rsp_err) err_count <= sat_inc(err_count);
            else         ok_count  <= sat_inc(ok_count);
        end
    end
`endif

endmodule

// File: tb/tb_command_decoder.sv
// ----------------------------------------------------------------------------
// tb_command_decoder
//   Directed-vector bench for command_decoder (NUM_REGS = 8). Stimulus pushes
//   the hand-computed response of each command into a queue; a monitor pops
//   and compares on every response handshake.
// ----------------------------------------------------------------------------
module tb_command_decoder;

    localparam int NUM_REGS = 8;

    logic                    clk;
    logic                    reset;
    logic [NUM_REGS*32-1:0]  cfg;
    logic [31:0]             status;

    command_decoder_if bus ();

    command_decoder #(.NUM_REGS(NUM_REGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .o_cfg    (cfg),
        .i_status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_q [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake occurs at the next rising edge whenever valid and
    // ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!reset && bus.o_rsp_valid && bus.i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h expected none", bus.o_rsp_data);
            end else begin
                check("rsp", {208'h0, bus.o_rsp_data}, {208'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.o_msg_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.o_msg_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [31:0] d,
                        input logic [47:0] exp, input bit has_rsp);
        wait_ready();
        if (has_rsp) exp_q.push_back(exp);
        bus.i_msg_data  = {op, a, d};
        bus.i_msg_valid = 1'b1;
        tick();
        bus.i_msg_valid = 1'b0;
        bus.i_msg_data  = 48'hFFFF_FFFF_FFFF;
    endtask

    logic [NUM_REGS*32-1:0] snap;

    initial begin
        reset           = 1'b1;
        status          = 32'h0;
        bus.i_msg_valid = 1'b0;
        bus.i_msg_data  = 48'h0;
        bus.i_rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_msg_ready", {255'h0, bus.o_msg_ready}, 256'h0);
        check("rst_rsp_valid", {255'h0, bus.o_rsp_valid}, 256'h0);
        check("rst_rsp_data", {208'h0, bus.o_rsp_data}, 256'h0);
        check("rst_cfg", cfg, 256'h0);
        reset = 1'b0;
        check("ready_before_edge", {255'h0, bus.o_msg_ready}, 256'h0);
        tick();
        check("ready_after_reset", {255'h0, bus.o_msg_ready}, 256'h1);

        // WRITE with latency check: accept at N, visible after N+2
        send(8'h01, 8'h03, 32'hDEADBEEF, 48'h0103_DEADBEEF, 1'b1);
        check("wr_valid_n", {255'h0, bus.o_rsp_valid}, 256'h0);
        tick();
        check("wr_valid_n1", {255'h0, bus.o_rsp_valid}, 256'h0);
        check("wr_cfg_n1", {224'h0, cfg[127:96]}, 256'h0);
        tick();
        check("wr_valid_n2", {255'h0, bus.o_rsp_valid}, 256'h1);
        check("wr_cfg_n2", {224'h0, cfg[127:96]}, {224'h0, 32'hDEADBEEF});
        check("wr_ready_busy", {255'h0, bus.o_msg_ready}, 256'h0);
        send(8'h02, 8'h03, 32'h0, 48'h0203_DEADBEEF, 1'b1);

        // Illegal opcode, then out-of-map write; bank unchanged
        wait_ready();
        snap = cfg;
        send(8'h7A, 8'h00, 32'h12345678, 48'hE000_00000000, 1'b1);
        send(8'h01, 8'h08, 32'h11111111, 48'hE108_00000000, 1'b1);
        send(8'h55, 8'hFF, 32'h1, 48'hE0FF_00000000, 1'b1);
        wait_ready();
        check("bad_cfg_unchanged", cfg, snap);

        // Status word and register boundary
        status = 32'h12345678;
        send(8'h02, 8'hFF, 32'h0, 48'h02FF_12345678, 1'b1);
        send(8'h01, 8'hFF, 32'h99, 48'hE1FF_00000000, 1'b1);
        send(8'h02, 8'h08, 32'h0, 48'hE108_00000000, 1'b1);
        send(8'h01, 8'h07, 32'h76543210, 48'h0107_76543210, 1'b1);
        send(8'h02, 8'h00, 32'h0, 48'h0200_00000000, 1'b1);
        wait_ready();
        check("cfg_reg7", {224'h0, cfg[255:224]}, {224'h0, 32'h76543210});

        // PING held under backpressure
        bus.i_rsp_ready = 1'b0;
        send(8'h03, 8'h55, 32'hCAFEF00D, 48'h0355_CAFEF00D, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {255'h0, bus.o_rsp_valid}, 256'h1);
            check("hold_data", {208'h0, bus.o_rsp_data}, {208'h0, 48'h0355_CAFEF00D});
            check("hold_ready", {255'h0, bus.o_msg_ready}, 256'h0);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        check("release_ready", {255'h0, bus.o_msg_ready}, 256'h1);
        check("release_valid", {255'h0, bus.o_rsp_valid}, 256'h0);

        // Reset while in DECODE discards the command
        send(8'h01, 8'h01, 32'hA5A5A5A5, 48'h0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("midrst_ready", {255'h0, bus.o_msg_ready}, 256'h1);
        check("midrst_cfg", cfg, 256'h0);
        check("midrst_rsp_data", {208'h0, bus.o_rsp_data}, 256'h0);
        repeat (4) begin
            tick();
            check("midrst_no_rsp", {255'h0, bus.o_rsp_valid}, 256'h0);
        end

`ifdef CMD_DECODER_STATS_EN
        send(8'h01, 8'h00, 32'h1, 48'h0100_00000001, 1'b1);
        send(8'h02, 8'h00, 32'h0, 48'h0200_00000001, 1'b1);
        send(8'h03, 8'h10, 32'h2, 48'h0310_00000002, 1'b1);
        send(8'h00, 8'h00, 32'h0, 48'hE000_00000000, 1'b1);
        send(8'hFF, 8'h01, 32'h0, 48'hE001_00000000, 1'b1);
        send(8'h02, 8'hFE, 32'h0, 48'h02FE_00020003, 1'b1);
        send(8'h01, 8'hFE, 32'h0, 48'h01FE_00000000, 1'b1);
        send(8'h02, 8'hFE, 32'h0, 48'h02FE_00000001, 1'b1);
`else
        send(8'h02, 8'hFE, 32'h0, 48'hE1FE_00000000, 1'b1);
        send(8'h01, 8'hFE, 32'h5, 48'hE1FE_00000000, 1'b1);
`endif

        wait_ready();
        tick();
        check("queue_drained", {224'h0, 32'(exp_q.size())}, 256'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
